seq_shift_add_multiplier: RTL

- Parametrised, sequential radix-2 shift-and-add multiplier. Successor to the team's combinational 4x4 array multiplier.
- Produces a 2*WIDTH-bit product from two WIDTH-bit operands, computing one partial product per clock.
- Supports unsigned and two's-complement signed operands, selected per transaction.
- Sits behind valid/ready handshakes on both input and output, so it can be placed between pin-level I/O registers and downstream logic that may stall.

---
 rtl/seq_shift_add_multiplier.sv | 137 +++++++++++++
 1 files changed

// File: rtl/seq_shift_add_multiplier.sv
// Sequential radix-2 shift-and-add multiplier.
// Retires one partial product per clock and supports unsigned or
// two's-complement operands, selected per transaction.
// Valid/ready handshakes sit on both the operand side and the product side.
module seq_shift_add_multiplier #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  mag_a_q;
    logic [WIDTH-1:0]  mag_b_q;
    logic              neg_q;
    logic [CW-1:0]     cnt_q;
    logic [PW-1:0]     acc_q;
    logic [PW-1:0]     product_q;
    logic              out_valid_q;
    logic              in_ready_q;
    logic              busy_q;

    logic [WIDTH-1:0]  mag_a_d;
    logic [WIDTH-1:0]  mag_b_d;
    logic              neg_d;
    logic [PW-1:0]     pp_d;
    logic [PW-1:0]     acc_d;
    logic [PW-1:0]     product_d;

    // Operand conditioning: magnitudes plus result sign, taken at the accept edge.
    // The most negative value maps onto 2^(WIDTH-1), which still fits unsigned.
    always_comb begin
        mag_a_d = a;
        mag_b_d = b;
        neg_d   = 1'b0;
        if (signed_mode) begin
            if (a[WIDTH-1]) begin
                mag_a_d = (~a) + WIDTH'(1);
            end
            if (b[WIDTH-1]) begin
                mag_b_d = (~b) + WIDTH'(1);
            end
            neg_d = a[WIDTH-1] ^ b[WIDTH-1];
        end
    end

    // One shift-and-add step; the final result is negated when the signs differ.
    always_comb begin
        pp_d = '0;
        if (mag_b_q[cnt_q]) begin
            pp_d = PW'(mag_a_q) << cnt_q;
        end
        acc_d     = acc_q + pp_d;
        product_d = neg_q ? ((~acc_d) + PW'(1)) : acc_d;
    end

    // Control FSM and datapath registers; every output is a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mag_a_q     <= '0;
            mag_b_q     <= '0;
            neg_q       <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        mag_a_q    <= mag_a_d;
                        mag_b_q    <= mag_b_d;
                        neg_q      <= neg_d;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        state_q    <= S_BUSY;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_BUSY: begin
                    acc_q <= acc_d;
                    if (cnt_q == LAST_BIT) begin
                        product_q   <= product_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    // Product is deliberately left in place after the handoff.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = product_q;
    assign busy      = busy_q;

endmodule
